// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: FSM state encoding and default parameters for the reset sequencer
// Contents: state_e (RST/DLY/ACK/DONE), DEF_* defaults, max2 helper for counter sizing.
package rst_seq_pkg;
  typedef enum logic [1:0] {ST_RST, ST_DLY, ST_ACK, ST_DONE} state_e;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_STAGE_DLY = 16;
  localparam int DEF_ACK_TIMEOUT = 255;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rst_sync.sv
// rst_sync: 2-flop reset synchroniser, asynchronous assert / synchronous deassert
// Ports: clk_i clock, rst_i async active-high reset in,
//        rst_o synchronised reset (second flop), rst_early_o first flop (drops one edge earlier).
module rst_sync (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o,
  output logic rst_early_o
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], 1'b0};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= 2'b11;
    else sync_q <= sync_d;
  assign rst_o = sync_q[1];
  assign rst_early_o = sync_q[0];
endmodule

// File: rtl/rst_seq.sv
// rst_seq: sequenced release of NUM_STAGES reset domains after a global async reset
// Ports: clk_i clock, async_rst_i async active-high reset, soft_rst_i sync re-run request,
//        stage_ack_i per-stage ready acks, stage_rst_o per-stage resets (bit 0 first),
//        sys_ready_o all released, timeout_o sticky ack timeout, stage_idx_o current stage.
// Config: define RST_SEQ_ACK_EN to wait for stage_ack_i (with timeout) after each release;
//         without it stages release back to back every STAGE_DLY clocks and timeout_o is 0.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STAGE_DLY = DEF_STAGE_DLY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  async_rst_i,
  input  logic                  soft_rst_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  sys_ready_o,
  output logic                  timeout_o,
  output logic [2:0]            stage_idx_o
);
  localparam int CW = $clog2(max2(STAGE_DLY, ACK_TIMEOUT)) + 1;
  localparam logic [CW-1:0] DLY_END = CW'(STAGE_DLY - 1);
  localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d, rel;
  logic ready_q, ready_d, to_q, to_d, last, sync_rst, sync_early;
  rst_sync u_sync (
    .clk_i      (clk_i),
    .rst_i      (async_rst_i),
    .rst_o      (sync_rst),
    .rst_early_o(sync_early)
  );
  assign rel = NUM_STAGES'(1) << idx_q;
  assign last = idx_q == LAST;
`ifdef RST_SEQ_ACK_EN
  localparam logic [CW-1:0] ACK_END = CW'(ACK_TIMEOUT - 1);
  logic [7:0] ack_w;
  assign ack_w = 8'(stage_ack_i);
`else
  logic unused_ack;
  assign unused_ack = ^stage_ack_i;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    stage_d = stage_q;
    ready_d = ready_q;
    to_d = to_q;
    case (state_q)
      // Leave RST on the same edge the synchroniser output deasserts.
      ST_RST: state_d = sync_early ? ST_RST : ST_DLY;
      ST_DLY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DLY_END) begin
          cnt_d = '0;
          stage_d = stage_q & ~rel;
`ifdef RST_SEQ_ACK_EN
          state_d = ST_ACK;
`else
          state_d = last ? ST_DONE : ST_DLY;
          ready_d = last;
          idx_d = last ? idx_q : idx_q + 1'b1;
`endif
        end
      end
`ifdef RST_SEQ_ACK_EN
      ST_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (ack_w[idx_q] || cnt_q == ACK_END) begin
          cnt_d = '0;
          // A late ack on the timeout cycle still counts as a clean ack.
          to_d = to_q | ~ack_w[idx_q];
          state_d = last ? ST_DONE : ST_DLY;
          ready_d = last;
          idx_d = last ? idx_q : idx_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
    if (soft_rst_i && state_q != ST_RST) begin
      state_d = ST_DLY;
      cnt_d = '0;
      idx_d = '0;
      stage_d = '1;
      ready_d = 1'b0;
      to_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge async_rst_i)
    if (async_rst_i) begin
      state_q <= ST_RST;
      cnt_q <= '0;
      idx_q <= '0;
      stage_q <= '1;
      ready_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      to_q <= to_d;
    end
  // Hold every stage while the synchronised reset is still asserted.
  assign stage_rst_o = stage_q | {NUM_STAGES{sync_rst}};
  assign sys_ready_o = ready_q;
  assign stage_idx_o = idx_q;
`ifdef RST_SEQ_ACK_EN
  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: randomized scoreboard bench for rst_seq against an event-timeline model
module tb_rst_seq;
  localparam int N = 4;
  localparam int SD = 16;
  localparam int AT = 255;
  localparam logic [8:0] RV = {4'hF, 1'b0, 1'b0, 3'd0};
  typedef struct {
    int         t;
    logic [8:0] v;
  } ev_t;
  logic clk = 1'b0;
  logic async_rst = 1'b0;
  logic soft_rst = 1'b0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] stage_rst;
  logic sys_ready, timeout;
  logic [2:0] stage_idx;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int ack_at[N];
  int dly_k[N];
  ev_t q[$];
  logic [8:0] mcur = RV;
  logic [8:0] prev = RV;
  rst_seq #(.NUM_STAGES(N), .STAGE_DLY(SD), .ACK_TIMEOUT(AT)) dut (
    .clk_i      (clk),
    .async_rst_i(async_rst),
    .soft_rst_i (soft_rst),
    .stage_ack_i(ack),
    .stage_rst_o(stage_rst),
    .sys_ready_o(sys_ready),
    .timeout_o  (timeout),
    .stage_idx_o(stage_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [8:0] dv();
    return {stage_rst, sys_ready, timeout, stage_idx};
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask
  // Timeline model: t0 is the edge on which delay counting for stage 0 starts.
  // Each stage is released SD edges after its delay starts; with acks enabled the
  // sequencer then waits until the ack is seen (dly_k edges late) or AT edges pass.
  task automatic plan(input int t0);
    int t = t0;
    logic [3:0] st = 4'hF;
    logic rdy = 1'b0;
    logic to = 1'b0;
    logic [2:0] idx = 3'd0;
    for (int k = 0; k < N; k++) begin
      t += SD;
      st[k] = 1'b0;
      ack_at[k] = t + dly_k[k];
`ifdef RST_SEQ_ACK_EN
      q.push_back('{t, {st, rdy, to, idx}});
      if (dly_k[k] < AT) t += dly_k[k] + 1;
      else begin
        t += AT;
        to = 1'b1;
      end
`endif
      if (k == N - 1) rdy = 1'b1;
      else idx = 3'(k + 1);
      q.push_back('{t, {st, rdy, to, idx}});
    end
  endtask
  task automatic hold_reset();
    @(posedge clk);
    #2 async_rst = 1'b1;
    q.delete();
    if (mcur !== RV) q.push_back('{cyc, RV});
    #1 check("async_assert", 32'(dv()), 32'(RV));
    repeat (3) @(posedge clk);
  endtask
  task automatic release_rst();
    @(posedge clk);
    #2 async_rst = 1'b0;
    plan(cyc + 2);
  endtask
  task automatic soft_pulse();
    @(posedge clk);
    #2 soft_rst = 1'b1;
    q.delete();
    if (mcur !== RV) q.push_back('{cyc + 1, RV});
    plan(cyc + 1);
    @(posedge clk);
    #2 soft_rst = 1'b0;
  endtask
  task automatic drain();
    int b = 0;
    while (q.size() != 0 && b < 4000) begin
      @(negedge clk);
      b++;
    end
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending, expected 0", q.size());
      q.delete();
    end
    check("final_state", 32'(dv()), 32'(mcur));
  endtask
  // Ack driver: stage k's ack rises once the planned edge has passed.
  initial forever begin
    @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) ack[k] = cyc >= ack_at[k];
  end
  // Monitor: every output change must match the next scheduled event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (dv() !== prev) begin
        prev = dv();
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_change: got %h at edge %0d, expected no change", prev, cyc);
        end else begin
          e = q.pop_front();
          mcur = e.v;
          check("out_vec", 32'(prev), 32'(e.v));
          check("out_edge", cyc, e.t);
        end
      end
    end
  end
  initial begin
    for (int k = 0; k < N; k++) begin
      ack_at[k] = 1 << 30;
      dly_k[k] = 0;
    end
    #1 async_rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 soft_rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("soft_in_rst", 32'(dv()), 32'(RV));
    soft_rst = 1'b0;
    release_rst();
    drain();
    dly_k[2] = AT + 5;
    hold_reset();
    release_rst();
    drain();
    dly_k[2] = 0;
    soft_pulse();
    drain();
    dly_k[1] = AT - 1;
    hold_reset();
    release_rst();
    drain();
    dly_k[1] = AT;
    hold_reset();
    release_rst();
    drain();
    dly_k[1] = 0;
    hold_reset();
    release_rst();
    repeat (40) @(posedge clk);
    #2 check("pre_pulse", 32'(stage_rst), 32'(mcur[8:5]));
    hold_reset();
    release_rst();
    drain();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++)
        dly_k[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(AT - 2, AT + 20)) : int'($urandom_range(0, 12));
      if (r % 2 == 0) soft_pulse();
      else begin
        hold_reset();
        release_rst();
      end
      drain();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of sequenced reset domains (legal 1..8).
REQ-002 SHALL have parameter STAGE_DLY, default 16, clocks between release decisions (legal >=1).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255, max clocks waiting for a stage acknowledge (legal >=1).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-006 async_rst_i  input  1  asynchronous active-high global reset, driven by the SCU async_rst_o.
REQ-007 soft_rst_i  input  1  synchronous request to re-run the full sequence.
REQ-008 stage_ack_i  input  NUM_STAGES  per-stage "out of reset, ready" acknowledge, level-sensitive.
REQ-009 stage_rst_o  output  NUM_STAGES  per-stage active-high reset; bit 0 is released first.
REQ-010 sys_ready_o  output  1  high once every stage is released.
REQ-011 timeout_o  output  1  sticky flag: at least one stage acknowledge timed out.
REQ-012 stage_idx_o  output  3  index of the stage currently being sequenced.

Function
REQ-013 SHALL assert all stage_rst_o immediately (combinationally, asynchronously) while async_rst_i is high.
REQ-014 SHALL synchronise deassertion of async_rst_i through a 2-flop synchroniser; the FSM leaves reset on the 2nd rising edge that samples async_rst_i low.
REQ-015 FSM states SHALL be: RST, DLY, ACK, DONE.
REQ-016 RST -> DLY when synchronised reset drops; stage index k = 0, counter = 0.
REQ-017 DLY: counter increments each clock; when counter == STAGE_DLY-1, next edge clears stage_rst_o[k] and moves to ACK with the counter cleared.
REQ-018 ACK: if stage_ack_i[k] is sampled high, then k == NUM_STAGES-1 -> DONE, otherwise k++ -> DLY.
REQ-019 ACK: if the counter reaches ACK_TIMEOUT-1 with no acknowledge, SHALL set timeout_o and advance exactly as in REQ-018.
REQ-020 An acknowledge and a timeout in the same cycle: acknowledge wins; timeout_o unchanged.
REQ-021 stage_rst_o[0] SHALL fall exactly 2+STAGE_DLY rising edges after the first edge sampling async_rst_i low.
REQ-022 Stages released earlier SHALL stay released; release order is strictly ascending and never skipped.
REQ-023 DONE: sys_ready_o = 1, registered, asserted on the edge entering DONE.
REQ-024 soft_rst_i sampled high in DLY, ACK or DONE: next edge asserts all stage_rst_o, clears sys_ready_o and timeout_o, sets k = 0 and counter = 0, enters DLY.
REQ-025 soft_rst_i in RST SHALL be ignored.
REQ-026 stage_idx_o = k, zero-extended; it holds NUM_STAGES-1 in DONE.
REQ-027 Counter width SHALL be $clog2(max(STAGE_DLY, ACK_TIMEOUT))+1; it never wraps.

Reset
REQ-028 async_rst_i high at any time, including mid-sequence, SHALL give: state RST, stage_rst_o all ones, sys_ready_o 0, timeout_o 0, stage_idx_o 0, counter 0, synchroniser flops 1.

Configuration
REQ-029 Macro RST_SEQ_ACK_EN defined: the ACK state, stage_ack_i and the timeout logic are present as specified above.
REQ-030 Macro RST_SEQ_ACK_EN undefined: no ACK state; DLY completion releases stage k and goes to DLY for k+1, or to DONE after the last stage; stage_ack_i is ignored; timeout_o is tied to 0.

Structure
REQ-031 Package rst_seq_pkg SHALL hold the FSM state encoding typedef and the default constants for NUM_STAGES, STAGE_DLY and ACK_TIMEOUT.
REQ-032 Sub-module rst_sync SHALL implement the 2-flop asynchronous-assert / synchronous-deassert synchroniser; it is instantiated once.

Verification (NUM_STAGES=4, STAGE_DLY=16, ACK_TIMEOUT=255, macro defined unless noted)
REQ-033 async_rst_i falls, acknowledges tied high -> stage_rst_o goes 4'b1111 -> 1110 at edge 18 -> 1100 -> 1000 -> 0000; sys_ready_o = 1; timeout_o = 0.
REQ-034 stage_ack_i[2] held low -> after 255 clocks in ACK, timeout_o = 1, stage 3 is still released, sys_ready_o = 1.
REQ-035 async_rst_i pulsed high while stage_rst_o = 4'b1100 -> outputs go 4'b1111 asynchronously, same cycle; the sequence restarts from stage 0.
REQ-036 soft_rst_i for one cycle in DONE with timeout_o = 1 -> next edge gives stage_rst_o = 4'b1111, sys_ready_o = 0, timeout_o = 0; the full sequence repeats.
REQ-037 stage_ack_i[1] rises on the same cycle as the timeout -> timeout_o stays 0.
REQ-038 Macro undefined, acknowledges held low -> stages release every 16 clocks; sys_ready_o = 1 after the 4th release; timeout_o = 0.
